// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V core pipeline.
// Holds the memory-access size codes, stage_m FSM states and the E->M register layout.
package combi_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } stage_m_state_e;

    localparam logic [1:0] RS_MEM = 2'b01;

    // Size is kept as raw bits so the unused code 2'b11 can fall through to word.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [1:0]  mem_size;
        logic        mem_signed;
        logic        arm;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
    } em_reg_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = addr[0];
            default: is_misaligned = (addr != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/flopenr.sv
// Resettable flop with load enable; async active-high reset clears it.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_q <= '0;
        else if (i_en)
            o_q <= i_d;
    end

endmodule

// File: rtl/ldfmt.sv
// Load formatter: picks the addressed byte/half out of the read word and
// sign- or zero-extends it to 32 bits.
module ldfmt
    import combi_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_byte = i_data[7:0];
        case (i_addr)
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

        o_data = i_data;
        case (i_size)
            MEM_B:   o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/stage_m.sv
// Memory-access pipeline stage: E->M register, data-memory handshake FSM,
// store lane/strobe formatting and load alignment/extension.
module stage_m
    import combi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic [1:0]  MemSizeE,
    input  logic        MemSignedE,
    input  logic        armE,
    input  logic [4:0]  RdE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RdM,
    output logic        armM,
    output logic [31:0] ALUResultM,
    output logic [31:0] ReadDataM,
    output logic [31:0] PCPlus4M,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DStrb,
    input  logic        DGnt,
    input  logic        DRValid,
    input  logic [31:0] DRData,
    output logic        StallM,
    output logic        MisalignM
);

    em_reg_t        w_em_d;
    em_reg_t        w_em_q;
    stage_m_state_e r_state;
    stage_m_state_e w_state_next;
    logic           w_load;
    logic           w_store;
    logic           w_valid_op;
    logic           w_misalign;
    logic           w_mem_ok;
    logic           w_resp_done;
    logic [31:0]    w_ld_data;

    assign w_em_d = '{
        reg_write:  RegWriteE,
        mem_write:  MemWriteE,
        result_src: ResultSrcE,
        mem_size:   MemSizeE,
        mem_signed: MemSignedE,
        arm:        armE,
        rd:         RdE,
        alu_result: ALUResultE,
        write_data: WriteDataE,
        pc_plus4:   PCPlus4E
    };

    flopenr #(.WIDTH($bits(em_reg_t))) u_em_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (~StallM),
        .i_d  (w_em_d),
        .o_q  (w_em_q)
    );

    assign w_store    = w_em_q.mem_write;
    assign w_load     = (w_em_q.result_src == RS_MEM);
    assign w_valid_op = w_store | w_load;
    assign w_misalign = is_misaligned(w_em_q.mem_size, w_em_q.alu_result[1:0]);
    assign w_mem_ok   = w_valid_op & ~w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        DReq         = 1'b0;
        StallM       = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_ok) begin
                    DReq   = 1'b1;
                    StallM = ~(DGnt & w_store);
                    if (DGnt && !w_store)
                        w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (DRValid) begin
                    w_resp_done  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    ldfmt u_ldfmt (
        .i_addr   (w_em_q.alu_result[1:0]),
        .i_size   (w_em_q.mem_size),
        .i_signed (w_em_q.mem_signed),
        .i_data   (DRData),
        .o_data   (w_ld_data)
    );

    // Store lanes and strobes depend only on the registered op, so they hold while DReq waits for DGnt.
    always_comb begin
        DWData = w_em_q.write_data;
        DStrb  = 4'b0000;
        case (w_em_q.mem_size)
            MEM_B: begin
                DWData = {4{w_em_q.write_data[7:0]}};
                DStrb  = 4'b0001 << w_em_q.alu_result[1:0];
            end
            MEM_H: begin
                DWData = {2{w_em_q.write_data[15:0]}};
                DStrb  = w_em_q.alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                DWData = w_em_q.write_data;
                DStrb  = 4'b1111;
            end
        endcase
        if (!w_mem_ok)
            DStrb = 4'b0000;
    end

    assign DWe        = DReq & w_store;
    assign DAddr      = {w_em_q.alu_result[31:2], 2'b00};
    assign MisalignM  = w_valid_op & w_misalign;
    assign ReadDataM  = w_resp_done ? w_ld_data : 32'd0;
    assign RegWriteM  = w_em_q.reg_write & ~MisalignM;
    assign ResultSrcM = w_em_q.result_src;
    assign RdM        = w_em_q.rd;
    assign armM       = w_em_q.arm;
    assign ALUResultM = w_em_q.alu_result;
    assign PCPlus4M   = w_em_q.pc_plus4;

endmodule

// File: tb/tb_stage_m.sv
// Directed self-checking bench for stage_m: loads, stores, misalignment,
// reset during an outstanding load and back-to-back loads.
module tb_stage_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, MemSignedE, armE;
    logic [1:0]  ResultSrcE, MemSizeE;
    logic [4:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic        RegWriteM, armM, DReq, DWe, StallM, MisalignM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, DAddr, DWData;
    logic [3:0]  DStrb;
    logic        DGnt, DRValid;
    logic [31:0] DRData;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;

    always #5 clk = ~clk;

    stage_m dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .armE(armE), .RdE(RdE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .armM(armM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DStrb(DStrb),
        .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData),
        .StallM(StallM), .MisalignM(MisalignM)
    );

    task automatic set_e(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [1:0] sz, input logic sgn, input logic arm,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
        RegWriteE = rw;  MemWriteE = mw;  ResultSrcE = rs; MemSizeE = sz;
        MemSignedE = sgn; armE = arm; RdE = rd; ALUResultE = alu;
        WriteDataE = wd; PCPlus4E = pc4;
    endtask

    task automatic set_bubble();
        set_e(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // One full-vector check of every output against zero.
    task automatic test_reset();
        rst = 1'b1; DGnt = 1'b1; DRValid = 1'b1; DRData = 32'hDEAD_BEEF;
        set_e(1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 5'd31, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({RegWriteM, ResultSrcM, RdM, armM, ALUResultM, ReadDataM, PCPlus4M,
                         DReq, DWe, DAddr, DWData, DStrb, StallM, MisalignM} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero, DReq=%b StallM=%b DStrb=%b ReadDataM=%h", DReq, StallM, DStrb, ReadDataM);
        end
        @(negedge clk);
        rst = 1'b0; DGnt = 1'b0; DRValid = 1'b0; DRData = 32'd0;
        set_bubble();
    endtask

    task automatic test_nonmem();
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 5'd9, 32'hCAFE_0003, 32'h5555_5555, 32'h0000_0010);
        @(negedge clk);
        set_bubble(); #1;
        n_checks++; if ({ALUResultM, PCPlus4M, RdM, RegWriteM, armM} !== {32'hCAFE_0003, 32'h0000_0010, 5'd9, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL nonmem_pass: got alu=%h pc4=%h rd=%0d", ALUResultM, PCPlus4M, RdM);
        end
        n_checks++; if ({DReq, StallM, MisalignM, DStrb} !== 7'd0) begin
            n_fail++; $display("FAIL nonmem_quiet: got DReq=%b StallM=%b Mis=%b DStrb=%b want all 0", DReq, StallM, MisalignM, DStrb);
        end
    endtask

    task automatic test_lb_signed();
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 5'd5, 32'h0000_0103, 32'd0, 32'h0000_1004);
        stalls = 0;
        @(negedge clk);
        set_bubble(); DGnt = 1'b1; #1;
        if (StallM) stalls++;
        n_checks++; if ({DReq, DWe, DAddr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
            n_fail++; $display("FAIL lb_req: got DReq=%b DWe=%b DAddr=%h want 1 0 00000100", DReq, DWe, DAddr);
        end
        @(negedge clk);
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h80FF_1234; #1;
        if (StallM) stalls++;
        n_checks++; if (ReadDataM !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_data: got %h want ffffff80", ReadDataM);
        end
        n_checks++; if (DReq !== 1'b0) begin
            n_fail++; $display("FAIL lb_resp_noreq: got DReq=%b want 0", DReq);
        end
        @(negedge clk);
        DRValid = 1'b0; DRData = 32'd0; #1;
        n_checks++; if (stalls !== 1) begin
            n_fail++; $display("FAIL lb_stalls: got %0d want 1", stalls);
        end
        n_checks++; if ({StallM, RdM} !== {1'b0, 5'd0}) begin
            n_fail++; $display("FAIL lb_after: got StallM=%b RdM=%0d want 0 0", StallM, RdM);
        end
    endtask

    task automatic test_lhu_delayed_grant();
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 5'd7, 32'h0000_0102, 32'd0, 32'h0000_2008);
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_bubble(); DGnt = (c == 3); #1;
            if (StallM) stalls++;
            n_checks++; if ({DReq, DAddr} !== {1'b1, 32'h0000_0100}) begin
                n_fail++; $display("FAIL lhu_hold_c%0d: got DReq=%b DAddr=%h want 1 00000100", c, DReq, DAddr);
            end
        end
        @(negedge clk);
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h8001_0000; #1;
        if (StallM) stalls++;
        n_checks++; if (ReadDataM !== 32'h0000_8001) begin
            n_fail++; $display("FAIL lhu_data: got %h want 00008001", ReadDataM);
        end
        n_checks++; if (stalls !== 4) begin
            n_fail++; $display("FAIL lhu_stalls: got %0d want 4", stalls);
        end
        n_checks++; if ({armM, RdM} !== {1'b1, 5'd7}) begin
            n_fail++; $display("FAIL lhu_wb_fields: got arm=%b rd=%0d want 1 7", armM, RdM);
        end
        @(negedge clk);
        DRValid = 1'b0; DRData = 32'd0;
    endtask

    task automatic test_sb_sh();
        @(negedge clk);
        set_e(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0000_0201, 32'h1234_56AB, 32'd0);
        @(negedge clk);
        set_bubble(); DGnt = 1'b1; #1;
        n_checks++; if ({DReq, DWe, DStrb, DAddr} !== {1'b1, 1'b1, 4'b0010, 32'h0000_0200}) begin
            n_fail++; $display("FAIL sb_req: got DReq=%b DWe=%b DStrb=%b DAddr=%h", DReq, DWe, DStrb, DAddr);
        end
        n_checks++; if (DWData !== 32'hABAB_ABAB) begin
            n_fail++; $display("FAIL sb_data: got %h want abababab", DWData);
        end
        n_checks++; if (StallM !== 1'b0) begin
            n_fail++; $display("FAIL sb_nostall: got StallM=%b want 0", StallM);
        end
        set_e(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 32'h0000_0202, 32'hFFFF_BEEF, 32'd0);
        @(negedge clk);
        set_bubble(); DGnt = 1'b0; #1;
        n_checks++; if ({DReq, StallM, DStrb, DWData} !== {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF}) begin
            n_fail++; $display("FAIL sh_wait: got DReq=%b StallM=%b DStrb=%b DWData=%h", DReq, StallM, DStrb, DWData);
        end
        @(negedge clk);
        DGnt = 1'b1; #1;
        n_checks++; if ({DReq, StallM, DStrb} !== {1'b1, 1'b0, 4'b1100}) begin
            n_fail++; $display("FAIL sh_grant: got DReq=%b StallM=%b DStrb=%b want 1 0 1100", DReq, StallM, DStrb);
        end
        @(negedge clk);
        DGnt = 1'b0; #1;
        n_checks++; if ({DReq, DStrb} !== {1'b0, 4'b0000}) begin
            n_fail++; $display("FAIL sh_done: got DReq=%b DStrb=%b want 0 0000", DReq, DStrb);
        end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        set_e(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 5'd3, 32'h0000_0202, 32'h1111_1111, 32'd0);
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 5'd4, 32'h0000_0101, 32'd0, 32'd0);
        DGnt = 1'b1; #1;
        n_checks++; if ({DReq, MisalignM, RegWriteM, StallM} !== 4'b0100) begin
            n_fail++; $display("FAIL sw_misalign: got DReq=%b Mis=%b RegW=%b Stall=%b want 0 1 0 0", DReq, MisalignM, RegWriteM, StallM);
        end
        @(negedge clk);
        set_bubble(); #1;
        n_checks++; if ({DReq, MisalignM, RegWriteM, StallM} !== 4'b0100) begin
            n_fail++; $display("FAIL lh_misalign: got DReq=%b Mis=%b RegW=%b Stall=%b want 0 1 0 0", DReq, MisalignM, RegWriteM, StallM);
        end
        @(negedge clk);
        DGnt = 1'b0; #1;
        n_checks++; if (MisalignM !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got %b want 0", MisalignM);
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 5'd6, 32'h0000_0300, 32'd0, 32'd0);
        @(negedge clk);
        set_bubble(); DGnt = 1'b1;
        @(negedge clk);
        DGnt = 1'b0; #1;
        n_checks++; if ({StallM, DReq} !== 2'b10) begin
            n_fail++; $display("FAIL resp_wait: got StallM=%b DReq=%b want 1 0", StallM, DReq);
        end
        rst = 1'b1; #1;
        n_checks++; if ({StallM, RegWriteM, RdM, ALUResultM} !== '0) begin
            n_fail++; $display("FAIL resp_rst: got StallM=%b RdM=%0d ALU=%h want 0", StallM, RdM, ALUResultM);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        DRValid = 1'b1; DRData = 32'h7777_7777; #1;
        n_checks++; if ({StallM, DReq, ReadDataM} !== '0) begin
            n_fail++; $display("FAIL stale_rvalid: got StallM=%b DReq=%b ReadDataM=%h want 0", StallM, DReq, ReadDataM);
        end
        @(negedge clk);
        DRValid = 1'b0; DRData = 32'd0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 5'd1, 32'h0000_0400, 32'd0, 32'h0000_0104);
        @(negedge clk);
        set_e(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 5'd2, 32'h0000_0408, 32'd0, 32'h0000_0108);
        DGnt = 1'b1; #1;
        n_checks++; if ({DReq, StallM, ALUResultM} !== {1'b1, 1'b1, 32'h0000_0400}) begin
            n_fail++; $display("FAIL b2b_first_req: got DReq=%b StallM=%b ALU=%h", DReq, StallM, ALUResultM);
        end
        @(negedge clk);
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h1111_2222; #1;
        n_checks++; if ({StallM, DReq, ReadDataM, RdM} !== {1'b0, 1'b0, 32'h1111_2222, 5'd1}) begin
            n_fail++; $display("FAIL b2b_first_resp: got StallM=%b DReq=%b data=%h rd=%0d", StallM, DReq, ReadDataM, RdM);
        end
        @(negedge clk);
        set_bubble(); DRValid = 1'b0; DRData = 32'd0; #1;
        n_checks++; if ({DReq, DAddr, ALUResultM, RdM} !== {1'b1, 32'h0000_0408, 32'h0000_0408, 5'd2}) begin
            n_fail++; $display("FAIL b2b_second_req: got DReq=%b DAddr=%h ALU=%h rd=%0d", DReq, DAddr, ALUResultM, RdM);
        end
        DGnt = 1'b1;
        @(negedge clk);
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h3333_4444; #1;
        n_checks++; if ({StallM, ReadDataM, PCPlus4M} !== {1'b0, 32'h3333_4444, 32'h0000_0108}) begin
            n_fail++; $display("FAIL b2b_second_resp: got StallM=%b data=%h pc4=%h", StallM, ReadDataM, PCPlus4M);
        end
        @(negedge clk);
        DRValid = 1'b0; DRData = 32'd0;
    endtask

    initial begin
        set_bubble();
        test_reset();
        test_nonmem();
        test_lb_signed();
        test_lhu_delayed_grant();
        test_sb_sh();
        test_misalign();
        test_reset_in_resp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_m.md
# stage_m

Memory-access pipeline stage of the combined ARM/RISC-V core, directly downstream of the execute stage. Registers the execute-stage results, runs the data-memory request/response handshake, and stalls the pipeline while an access is outstanding. Formats store data and byte strobes, and aligns and sign- or zero-extends load data. Passes everything the writeback stage needs.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  core clock
- rst  in  1  reset; asynchronous and active-high
- RegWriteE, MemWriteE  in  1 each  control bits from execute
- ResultSrcE  in  2  result select; bit 1 is RISC-V only
- MemSizeE  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- MemSignedE  in  1  sign-extend loads
- armE  in  1  instruction is ARM
- RdE  in  5  destination register
- ALUResultE, WriteDataE, PCPlus4E  in  32 each  execute results
- RegWriteM  out  1  to writeback
- ResultSrcM  out  2  to writeback
- RdM  out  5  to writeback
- armM  out  1  to writeback
- ALUResultM  out  32  to writeback; also the forwarding source for execute
- ReadDataM  out  32  to writeback
- PCPlus4M  out  32  to writeback
- DReq  out  1  memory request
- DWe  out  1  request is a write
- DAddr  out  32  word address, {ALUResultM[31:2], 2'b00}
- DWData  out  32  store data
- DStrb  out  4  byte strobes
- DGnt  in  1  request accepted
- DRValid  in  1  read response valid
- DRData  in  32  read response data
- StallM  out  1  to hazard unit; freezes F/D/E and the E→M register
- MisalignM  out  1  one-cycle misalignment flag

## Operation
- E→M register holds RegWrite, MemWrite, ResultSrc, MemSize, MemSigned, arm, Rd, ALUResult, WriteData and PCPlus4.
  - It loads every clock edge unless StallM=1, in which case it holds.
  - Async reset clears it, which makes it a bubble.
- A memory op is valid when MemWriteM=1, or ResultSrcM=01 (load).
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
  - DReq is not raised and no stall occurs.
  - MisalignM=1 for that cycle.
  - RegWriteM is forced to 0.
- Strobes:
  - byte: 0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- DWData replicates the store lane: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load format: select the byte or half from DRData by addr[1:0], then sign-extend if MemSigned, else zero-extend.
- FSM states are IDLE and RESP.
  - IDLE with a valid, aligned op: DReq=1, DWe=MemWriteM, held stable until DGnt.
    - DGnt on a store: done and no stall in that cycle; stay in IDLE.
    - DGnt on a load: go to RESP.
  - RESP: DReq=0; wait for DRValid.
    - On DRValid: ReadDataM = formatted DRData (combinational), StallM=0, go to IDLE.
- StallM = (IDLE & validop & aligned & ~(DGnt & store)) | (RESP & ~DRValid).
- DRValid in IDLE (stray, or after reset) is ignored.
- DGnt is ignored when DReq=0.

## Timing
- Reset values: every output 0; FSM in IDLE.
- A reset during RESP drops the outstanding load; its later DRValid is ignored.
- Latency, with the clock edge at which the E→M register loads counted as cycle 0:
  - Store with same-cycle DGnt: zero stall cycles.
  - Each cycle without DGnt adds one stall.
- A load needs at least 1 stall cycle: grant in cycle 1, DRValid no earlier than cycle 2.
- Non-memory ops: zero stall, pure one-register latency.
- Once DReq is asserted, DAddr, DWe, DWData and DStrb stay constant until DGnt.
- ReadDataM is valid only in the cycle StallM falls for a load. Writeback samples it at that edge.
- A back-to-back memory op enters at the edge where StallM=0 and may raise DReq in the next cycle.

## Structure
- Shared package combi_pkg holds:
  - the MemSize enum (MEM_B, MEM_H, MEM_W)
  - the stage_m state enum (S_IDLE, S_RESP)
  - the ResultSrc load code (RS_MEM=2'b01)
- The E→M register reuses the async-reset enabled flop flopenr.
- One sub-module, ldfmt: combinational load lane-select and extension (addr[1:0], size, signed, DRData → ReadDataM).

## Test plan
- lb, signed, from address 0x103 with DRValid data 0x80FF_1234 one cycle after grant → ReadDataM=0xFFFF_FF80, 1 stall cycle.
- lhu from 0x102 with grant delayed 3 cycles, data 0x8001_0000 → ReadDataM=0x0000_8001, 4 stall cycles, DAddr=0x100 constant throughout.
- sb of 0xAB to 0x201 with same-cycle DGnt → DStrb=0010, DWData=0xABABABAB, StallM never asserted.
- sw to 0x202 → no DReq, MisalignM pulses 1 cycle, RegWriteM=0, no stall.
- Assert rst while in RESP, then DRValid=1 two cycles later → FSM stays IDLE, outputs 0, no stall.
- Back-to-back lw, lw each with 1-cycle response → DReq for the second appears the cycle after the first's StallM falls, and the forwarded ALUResultM is correct.
